// File: rtl/milano_dmem_slave.sv
// rtl/milano_dmem_slave.sv - data-memory responder (req/gnt/rvalid) with byte-enable writes and grant wait states
// Optional MILANO_DMEM_ERR_EN: adds data_err_o and returns 32'hDEAD_BEEF for out-of-range reads.
module milano_dmem_slave #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned GNT_WAIT    = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
`ifdef MILANO_DMEM_ERR_EN
    output logic        data_err_o,
`endif
    output logic [31:0] data_rdata_o
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT  = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WAIT_N = 4'(GNT_WAIT);
`ifdef MILANO_DMEM_ERR_EN
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] OOR_DATA = 32'h0000_0000;
`endif

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_raw;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] mem_q [DEPTH_WORDS];

    // The subtraction wraps for addresses below BASE_ADDR, so one unsigned compare covers both sides.
    assign off      = data_addr_i - BASE_ADDR;
    assign in_range = ({1'b0, off} < LIMIT);
    assign idx      = off[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (data_req_i) begin
                    if (GNT_WAIT == 0) begin
                        gnt_raw = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!data_req_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WAIT_N) begin
                    gnt_raw = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Grant is held low throughout reset so that no write can commit while rst_ni is asserted.
    assign data_gnt_o = gnt_raw & rst_ni;

    always_ff @(posedge clk_i) begin
        if (data_gnt_o && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem_q[idx];
        if (!in_range) begin
            rd_word = OOR_DATA;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= data_gnt_o;
            if (data_gnt_o) begin
                rdata_q <= data_we_i ? 32'h0000_0000 : rd_word;
            end
        end
    end

`ifdef MILANO_DMEM_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (data_gnt_o) begin
            err_q <= !in_range || (data_we_i && (data_be_i == 4'b0000));
        end else begin
            err_q <= 1'b0;
        end
    end

    assign data_err_o = err_q;
`endif

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_milano_dmem_slave.sv
// tb/tb_milano_dmem_slave.sv - scoreboard bench: DUT0 with GNT_WAIT=0, DUT1 with GNT_WAIT=3
module tb_milano_dmem_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;

    int errors = 0;
    int checks = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] model [2][DEPTH];
    logic        pg0 = 1'b0, pg1 = 1'b0;
    logic [32:0] e0, e1;

    always #5 clk = ~clk;

    milano_dmem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_WAIT(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_gnt_o(gnt0),
        .data_rvalid_o(rv0), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
        .data_wdata_i(wdata),
`ifdef MILANO_DMEM_ERR_EN
        .data_err_o(err0),
`endif
        .data_rdata_o(rd0)
    );

    milano_dmem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .GNT_WAIT(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_gnt_o(gnt1),
        .data_rvalid_o(rv1), .data_addr_i(addr), .data_we_i(we), .data_be_i(be),
        .data_wdata_i(wdata),
`ifdef MILANO_DMEM_ERR_EN
        .data_err_o(err1),
`endif
        .data_rdata_o(rd1)
    );

`ifndef MILANO_DMEM_ERR_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

    // Response monitor: rvalid must follow every gnt by one cycle, data popped in grant order.
    always @(negedge clk) begin
        if (!rst_n) begin
            pg0 = 1'b0;
            pg1 = 1'b0;
        end else begin
            if (rv0 || pg0) begin
                checks++;
                if (rv0 !== pg0) begin
                    errors++;
                    $display("FAIL rvalid0_timing: got %0b expected %0b", rv0, pg0);
                end
            end
            if (rv1 || pg1) begin
                checks++;
                if (rv1 !== pg1) begin
                    errors++;
                    $display("FAIL rvalid1_timing: got %0b expected %0b", rv1, pg1);
                end
            end
            if (rv0 === 1'b1 && q0.size() > 0) begin
                e0 = q0.pop_front();
                checks++;
                if (rd0 !== e0[31:0] || err0 !== e0[32]) begin
                    errors++;
                    $display("FAIL resp0: got rdata=%h err=%b expected rdata=%h err=%b", rd0, err0, e0[31:0], e0[32]);
                end
            end else if (rv0 === 1'b1) begin
                errors++;
                checks++;
                $display("FAIL resp0_unexpected: got rvalid with rdata=%h, expected none", rd0);
            end
            if (rv1 === 1'b1 && q1.size() > 0) begin
                e1 = q1.pop_front();
                checks++;
                if (rd1 !== e1[31:0] || err1 !== e1[32]) begin
                    errors++;
                    $display("FAIL resp1: got rdata=%h err=%b expected rdata=%h err=%b", rd1, err1, e1[31:0], e1[32]);
                end
            end else if (rv1 === 1'b1) begin
                errors++;
                checks++;
                $display("FAIL resp1_unexpected: got rvalid with rdata=%h, expected none", rd1);
            end
            pg0 = gnt0;
            pg1 = gnt1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the grant edge with the request still driven.
    task automatic do_txn(input int sel, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d, output int lat);
        logic [31:0] off;
        logic        inr;
        int          idx;
        logic [31:0] rv;
        logic        ev;
        addr  = a;
        we    = w;
        be    = b;
        wdata = d;
        if (sel == 0) req0 = 1'b1;
        else          req1 = 1'b1;
        off = a - BASE;
        inr = (off < DEPTH * 4);
        idx = int'(off[7:2]);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel == 0 ? gnt0 : gnt1) === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL gnt_timeout: dut%0d addr=%h got no gnt, expected gnt", sel, a);
        end else begin
            ev = 1'b0;
            rv = 32'h0;
            if (w) begin
                if (inr) begin
                    for (int k = 0; k < 4; k++)
                        if (b[k]) model[sel][idx][8*k +: 8] = d[8*k +: 8];
                end
`ifdef MILANO_DMEM_ERR_EN
                ev = !inr || (b == 4'h0);
`endif
            end else if (inr) begin
                rv = model[sel][idx];
            end else begin
`ifdef MILANO_DMEM_ERR_EN
                rv = 32'hDEAD_BEEF;
                ev = 1'b1;
`endif
            end
            if (sel == 0) q0.push_back({ev, rv});
            else          q1.push_back({ev, rv});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        req0 = 1'b0;
        req1 = 1'b0;
        we   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 6;
        if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
        if (rv0 !== 1'b0)  begin errors++; $display("FAIL reset_rvalid0: got %b expected 0", rv0); end
        if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata0: got %h expected 0", rd0); end
        if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
        if (rv1 !== 1'b0)  begin errors++; $display("FAIL reset_rvalid1: got %b expected 0", rv1); end
        if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected 0", rd1); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int lat;
        do_txn(0, BASE + 32'h10, 1'b1, 4'hF, 32'h1234_5678, lat);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL wr_latency: got %0d expected 0", lat); end
        do_txn(0, BASE + 32'h10, 1'b0, 4'hF, 32'h0, lat);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL rd_latency: got %0d expected 0", lat); end
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_be_merge();
        int lat;
        do_txn(0, BASE + 32'h20, 1'b1, 4'hF, 32'hAABB_CCDD, lat);
        do_txn(0, BASE + 32'h20, 1'b1, 4'b0101, 32'h1122_3344, lat);
        idle();
        do_txn(0, BASE + 32'h22, 1'b0, 4'b0001, 32'h0, lat);
        idle();
        checks++;
        if (model[0][8] !== 32'hAA22_CC44) begin
            errors++;
            $display("FAIL be_merge_model: got %h expected aa22cc44", model[0][8]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int tot = 0;
        for (int i = 0; i < 8; i++) begin
            do_txn(0, BASE + 32'h40 + 32'(i * 4), 1'b1, 4'hF, $urandom, lat);
            tot += lat;
        end
        for (int i = 0; i < 8; i++) begin
            do_txn(0, BASE + 32'h40 + 32'(i * 4), 1'b0, 4'hF, 32'h0, lat);
            tot += lat;
        end
        idle();
        checks++;
        if (tot !== 0) begin errors++; $display("FAIL stream_gaps: got %0d stall cycles expected 0", tot); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_out_of_range();
        int lat;
        do_txn(0, BASE, 1'b1, 4'hF, 32'h0BAD_F00D, lat);
        do_txn(0, BASE + DEPTH * 4, 1'b0, 4'hF, 32'h0, lat);
        do_txn(0, BASE - 32'h4, 1'b0, 4'hF, 32'h0, lat);
        do_txn(0, BASE + DEPTH * 4, 1'b1, 4'hF, 32'hFFFF_FFFF, lat);
        do_txn(0, BASE + 32'h10, 1'b1, 4'h0, 32'hFFFF_FFFF, lat);
        do_txn(0, BASE, 1'b0, 4'hF, 32'h0, lat);
        do_txn(0, BASE + 32'h10, 1'b0, 4'hF, 32'h0, lat);
        idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_wait_states();
        int lat;
        do_txn(1, BASE + 32'h8, 1'b1, 4'hF, 32'h5A5A_0001, lat);
        idle();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL ws_wr_latency: got %0d expected 3", lat); end
        do_txn(1, BASE + 32'h8, 1'b0, 4'hF, 32'h0, lat);
        idle();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL ws_rd_latency: got %0d expected 3", lat); end
        @(posedge clk);
        #1;
        addr = BASE + 32'h8;
        we   = 1'b0;
        req1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1 !== 1'b0) begin errors++; $display("FAIL ws_early_gnt: got %b expected 0", gnt1); end
            @(posedge clk);
            #1;
        end
        req1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (gnt1 !== 1'b0 || rv1 !== 1'b0) begin
                errors++;
                $display("FAIL ws_abort: got gnt=%b rvalid=%b expected 0/0", gnt1, rv1);
            end
        end
        @(posedge clk);
        #1;
        do_txn(1, BASE + 32'h8, 1'b0, 4'hF, 32'h0, lat);
        idle();
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL ws_after_abort: got %0d expected 3", lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat;
        do_txn(0, BASE + 32'h30, 1'b1, 4'hF, 32'hCAFE_F00D, lat);
        do_txn(0, BASE + 32'h30, 1'b0, 4'hF, 32'h0, lat);
        rst_n = 1'b0;
        idle();
        #1;
        void'(q0.pop_back());
        checks += 2;
        if (rv0 !== 1'b0)  begin errors++; $display("FAIL rstmid_rvalid: got %b expected 0", rv0); end
        if (rd0 !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", rd0); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, BASE + 32'h30, 1'b0, 4'hF, 32'h0, lat);
        do_txn(0, BASE + 32'h10, 1'b0, 4'hF, 32'h0, lat);
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_write_read();
        test_be_merge();
        test_back_to_back();
        test_out_of_range();
        test_wait_states();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
